led_frame_sequencer: RTL and testbench

//  8051 SFR-bus slave that owns a pixel frame buffer for the WS2812 serial LED chain.
//  The CPU writes GRB bytes through SFR registers, then issues START.
//  The block streams each 24-bit pixel to the bit-encoder over a valid/ready handshake.
//  It then holds the line idle for the latch gap and raises a frame-done flag for the CPU to poll.

---
 rtl/led_frame_sequencer.sv | 245 ++++++++++++++++++++++++
 tb/tb_led_frame_sequencer.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_frame_sequencer.sv
// led_frame_sequencer: 8051 SFR-bus slave holding an N_LEDS-pixel GRB frame buffer.
// The CPU fills the buffer byte by byte, then issues START. Each 24-bit pixel is streamed
// to the WS2812 bit encoder over valid/ready. The line is then held idle for the latch gap,
// and frame_done is raised.
//
// Optional feature macro: AUTO_REPEAT_EN
//   Defined   : CTRL bit1 controls back-to-back frame repeat. CPU writes are accepted
//               during LATCH.
//   Undefined : repeat is tied off, and all busy-state writes are dropped.
//
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   sfr_addr                 SFR address
//   controller_data_in       SFR write data
//   sfr_wr, sfr_rd           one-cycle SFR write/read strobes
//   controller_data_out      combinational SFR read data (IDX/STAT, else 8'h00)
//   pix_data, pix_valid      pixel {G,R,B} to encoder, registered
//   pix_ready                encoder accept
//   frame_done               level copy of STAT.done
module led_frame_sequencer #(
  parameter int unsigned N_LEDS       = 8,
  parameter int unsigned LATCH_CYCLES = 3000,
  parameter logic [7:0]  ADDR_DATA    = 8'hC1,
  parameter logic [7:0]  ADDR_IDX     = 8'hC2,
  parameter logic [7:0]  ADDR_CTRL    = 8'hC3,
  parameter logic [7:0]  ADDR_STAT    = 8'hC4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  sfr_addr,
  input  logic [7:0]  controller_data_in,
  input  logic        sfr_wr,
  input  logic        sfr_rd,
  output logic [7:0]  controller_data_out,
  output logic [23:0] pix_data,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic        frame_done
);

  localparam int unsigned IDX_W  = (N_LEDS > 1) ? $clog2(N_LEDS) : 1;
  localparam int unsigned LCNT_W = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_LATCH,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [IDX_W-1:0]    scnt_q, scnt_d;
  logic [LCNT_W-1:0]   lcnt_q, lcnt_d;
  logic [1:0]          lane_q, lane_d;
  logic [7:0]          g_q, g_d;
  logic [7:0]          r_q, r_d;
  logic                done_q, done_d;
  logic                ovr_q, ovr_d;
  logic [23:0]         pix_data_q, pix_data_d;
  logic                pix_valid_q, pix_valid_d;
  logic                repeat_q;
  logic [23:0]         mem_q [N_LEDS];
  logic                mem_we;
  logic [23:0]         mem_wdata;

  logic busy;
  logic wr_open;
  logic wr_data, wr_idx, wr_ctrl, rd_stat;

  // SFR decode
  assign wr_data = sfr_wr && (sfr_addr == ADDR_DATA);
  assign wr_idx  = sfr_wr && (sfr_addr == ADDR_IDX);
  assign wr_ctrl = sfr_wr && (sfr_addr == ADDR_CTRL);
  assign rd_stat = sfr_rd && (sfr_addr == ADDR_STAT);
  assign busy    = (state_q != S_IDLE);

`ifdef AUTO_REPEAT_EN
  // LATCH is the window in which the CPU may refresh the buffer between repeated frames
  assign wr_open = (state_q == S_IDLE) || (state_q == S_LATCH);

  logic repeat_d;

  // Repeat flag follows CTRL bit1 on every CTRL write, busy or not
  always_comb begin
    repeat_d = repeat_q;
    if (wr_ctrl) begin
      repeat_d = controller_data_in[1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      repeat_q <= 1'b0;
    end else begin
      repeat_q <= repeat_d;
    end
  end
`else
  assign wr_open  = (state_q == S_IDLE);
  assign repeat_q = 1'b0;
`endif

  // Next-state, buffer-write and status logic
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    scnt_d      = scnt_q;
    lcnt_d      = lcnt_q;
    lane_d      = lane_q;
    g_d         = g_q;
    r_d         = r_q;
    done_d      = done_q;
    ovr_d       = ovr_q;
    pix_data_d  = pix_data_q;
    pix_valid_d = pix_valid_q;
    mem_we      = 1'b0;
    mem_wdata   = {g_q, r_q, controller_data_in};

    // Clear-on-read first so that a same-cycle set below takes priority
    if (rd_stat) begin
      done_d = 1'b0;
      ovr_d  = 1'b0;
    end

    if ((wr_data || wr_idx) && !wr_open) begin
      ovr_d = 1'b1;
    end else if (wr_data) begin
      case (lane_q)
        2'd0: begin
          g_d    = controller_data_in;
          lane_d = 2'd1;
        end
        2'd1: begin
          r_d    = controller_data_in;
          lane_d = 2'd2;
        end
        default: begin
          mem_we = 1'b1;
          lane_d = 2'd0;
          idx_d  = (idx_q == IDX_W'(N_LEDS - 1)) ? '0 : idx_q + 1'b1;
        end
      endcase
    end else if (wr_idx) begin
      idx_d  = IDX_W'(32'(controller_data_in) % N_LEDS);
      lane_d = 2'd0;
    end

    case (state_q)
      S_IDLE: begin
        if (wr_ctrl && controller_data_in[0]) begin
          state_d = S_LOAD;
          scnt_d  = '0;
        end
      end
      S_LOAD: begin
        pix_data_d  = mem_q[scnt_q];
        pix_valid_d = 1'b1;
        state_d     = S_SEND;
      end
      S_SEND: begin
        if (pix_ready) begin
          pix_valid_d = 1'b0;
          if (scnt_q == IDX_W'(N_LEDS - 1)) begin
            state_d = S_LATCH;
            lcnt_d  = '0;
          end else begin
            scnt_d  = scnt_q + 1'b1;
            state_d = S_LOAD;
          end
        end
      end
      S_LATCH: begin
        lcnt_d = lcnt_q + 1'b1;
        if (lcnt_q == LCNT_W'(LATCH_CYCLES - 1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done_d = 1'b1;
        if (repeat_q) begin
          state_d = S_LOAD;
          scnt_d  = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      scnt_q      <= '0;
      lcnt_q      <= '0;
      lane_q      <= 2'd0;
      g_q         <= 8'h00;
      r_q         <= 8'h00;
      done_q      <= 1'b0;
      ovr_q       <= 1'b0;
      pix_data_q  <= 24'h000000;
      pix_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      scnt_q      <= scnt_d;
      lcnt_q      <= lcnt_d;
      lane_q      <= lane_d;
      g_q         <= g_d;
      r_q         <= r_d;
      done_q      <= done_d;
      ovr_q       <= ovr_d;
      pix_data_q  <= pix_data_d;
      pix_valid_q <= pix_valid_d;
    end
  end

  // Frame buffer: no reset, contents are undefined until written
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[idx_q] <= mem_wdata;
    end
  end

  // SFR read mux
  always_comb begin
    controller_data_out = 8'h00;
    if (sfr_addr == ADDR_IDX) begin
      controller_data_out = 8'(idx_q);
    end else if (sfr_addr == ADDR_STAT) begin
      controller_data_out = {busy, ovr_q, done_q, 5'b00000};
    end
  end

  assign pix_data   = pix_data_q;
  assign pix_valid  = pix_valid_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_led_frame_sequencer.sv
// Testbench for led_frame_sequencer: scoreboard with a behavioural frame-buffer model.
`timescale 1ns/1ps
module tb_led_frame_sequencer;

  localparam int N  = 8;
  localparam int LC = 3000;
  localparam logic [7:0] A_DATA = 8'hC1;
  localparam logic [7:0] A_IDX  = 8'hC2;
  localparam logic [7:0] A_CTRL = 8'hC3;
  localparam logic [7:0] A_STAT = 8'hC4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  sfr_addr;
  logic [7:0]  controller_data_in;
  logic        sfr_wr;
  logic        sfr_rd;
  logic [7:0]  controller_data_out;
  logic [23:0] pix_data;
  logic        pix_valid;
  logic        pix_ready = 1'b0;
  logic        frame_done;

  led_frame_sequencer #(.N_LEDS(N), .LATCH_CYCLES(LC)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .sfr_addr           (sfr_addr),
    .controller_data_in (controller_data_in),
    .sfr_wr             (sfr_wr),
    .sfr_rd             (sfr_rd),
    .controller_data_out(controller_data_out),
    .pix_data           (pix_data),
    .pix_valid          (pix_valid),
    .pix_ready          (pix_ready),
    .frame_done         (frame_done)
  );

  always #5 clk = ~clk;

  // Scoreboard queues (pushed by stimulus, popped by the monitor)
  logic [23:0] exp_pix_q [$];
  logic [7:0]  exp_rd_q  [$];
  string       rd_name_q [$];
  string       obs_name_q[$];
  logic [31:0] obs_act_q [$];
  logic [31:0] obs_exp_q [$];

  int vec  = 0;
  int errs = 0;
  int cyc  = 0;
  int last_hs_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state
  logic [23:0] m_buf [N];
  logic [7:0]  m_bytes [$];
  int          m_idx;
  bit          m_busy, m_done, m_ovr, m_repeat, m_latch_ok;

  // Ready driver: 0 always ready, 1 random, 2 stall 10 cycles on stall_val, 3 never ready
  int          rdy_mode = 0;
  logic [23:0] stall_val = 24'h0;
  int          stall_n = 0;

  always begin
    @(posedge clk);
    #1;
    if (rdy_mode == 0) begin
      pix_ready = 1'b1;
      stall_n   = 0;
    end else if (rdy_mode == 1) begin
      pix_ready = 1'($urandom_range(0, 1));
    end else if (rdy_mode == 2) begin
      if (pix_valid && pix_data == stall_val && stall_n < 10) begin
        pix_ready = 1'b0;
        stall_n   = stall_n + 1;
      end else begin
        pix_ready = 1'b1;
      end
    end else begin
      pix_ready = 1'b0;
    end
  end

  // Monitor: the only process that compares and steps the counters
  logic        prev_v = 1'b0, prev_hs = 1'b0;
  logic [23:0] prev_d = 24'h0;
  logic [23:0] e_pix;
  logic [7:0]  e_rd;
  string       nm_s;
  logic [31:0] oa, oe;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_v  = 1'b0;
      prev_hs = 1'b0;
    end else begin
      if (prev_v && !prev_hs) begin
        vec++;
        if (pix_valid !== 1'b1 || pix_data !== prev_d) begin
          errs++;
          $display("FAIL hold: valid=%0b data=%06h, required valid=1 data=%06h", pix_valid, pix_data, prev_d);
        end
      end
      if (pix_valid && pix_ready) begin
        vec++;
        if (exp_pix_q.size() == 0) begin
          errs++;
          $display("FAIL pixel: unexpected handshake data=%06h, required none", pix_data);
        end else begin
          e_pix = exp_pix_q.pop_front();
          if (pix_data !== e_pix) begin
            errs++;
            $display("FAIL pixel: got %06h, expected %06h", pix_data, e_pix);
          end
        end
        last_hs_cyc = cyc + 1;
      end
      prev_v  = pix_valid;
      prev_hs = pix_valid && pix_ready;
      prev_d  = pix_data;
    end
    if (sfr_rd) begin
      vec++;
      if (exp_rd_q.size() == 0) begin
        errs++;
        $display("FAIL sfr_read: unexpected read data=%02h", controller_data_out);
      end else begin
        e_rd = exp_rd_q.pop_front();
        nm_s = rd_name_q.pop_front();
        if (controller_data_out !== e_rd) begin
          errs++;
          $display("FAIL %s: got %02h, expected %02h", nm_s, controller_data_out, e_rd);
        end
      end
    end
    while (obs_name_q.size() > 0) begin
      nm_s = obs_name_q.pop_front();
      oa   = obs_act_q.pop_front();
      oe   = obs_exp_q.pop_front();
      vec++;
      if (oa !== oe) begin
        errs++;
        $display("FAIL %s: got %0d (%0h), expected %0d (%0h)", nm_s, oa, oa, oe, oe);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors, %0d miscompares", vec, errs);
    $fatal(1, "watchdog timeout");
  end

  // ---------------- stimulus helpers (enter and leave at posedge+1) ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic observe(input string nm, input logic [31:0] act, input logic [31:0] exp);
    obs_name_q.push_back(nm);
    obs_act_q.push_back(act);
    obs_exp_q.push_back(exp);
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    sfr_addr = a;
    controller_data_in = d;
    sfr_wr = 1'b1;
    tick(1);
    sfr_wr = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, input logic [7:0] exp, input string nm);
    exp_rd_q.push_back(exp);
    rd_name_q.push_back(nm);
    sfr_addr = a;
    sfr_rd = 1'b1;
    tick(1);
    sfr_rd = 1'b0;
  endtask

  task automatic rd_stat(input string nm);
    rd(A_STAT, {m_busy, m_ovr, m_done, 5'b00000}, nm);
    m_done = 1'b0;
    m_ovr  = 1'b0;
  endtask

  task automatic push_frame();
    for (int k = 0; k < N; k++) exp_pix_q.push_back(m_buf[k]);
  endtask

  task automatic data_wr(input logic [7:0] d);
    if (m_busy && !m_latch_ok) begin
      m_ovr = 1'b1;
    end else begin
      m_bytes.push_back(d);
      if (m_bytes.size() == 3) begin
        m_buf[m_idx] = {m_bytes[0], m_bytes[1], m_bytes[2]};
        m_bytes.delete();
        m_idx = (m_idx + 1) % N;
      end
    end
    wr(A_DATA, d);
  endtask

  task automatic idx_wr(input logic [7:0] d);
    if (m_busy && !m_latch_ok) begin
      m_ovr = 1'b1;
    end else begin
      m_idx = int'(d) % N;
      m_bytes.delete();
    end
    wr(A_IDX, d);
  endtask

  task automatic ctrl(input logic [7:0] d);
`ifdef AUTO_REPEAT_EN
    m_repeat = d[1];
`endif
    if (d[0] && !m_busy) begin
      push_frame();
      m_busy = 1'b1;
    end
    wr(A_CTRL, d);
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (frame_done !== 1'b1 && n < 6000) begin
      tick(1);
      n++;
    end
    observe({nm, "_done"}, 32'(frame_done), 32'd1);
    observe({nm, "_gap"}, 32'(cyc - last_hs_cyc), 32'(LC + 1));
    m_done = 1'b1;
    m_latch_ok = 1'b0;
    if (m_repeat) push_frame();
    else m_busy = 1'b0;
  endtask

  task automatic wait_drained(input string nm);
    int n = 0;
    while (exp_pix_q.size() != 0 && n < 2000) begin
      tick(1);
      n++;
    end
    observe(nm, 32'(exp_pix_q.size()), 32'd0);
  endtask

  task automatic end_frame_checks(input string nm);
    rd_stat({nm, "_stat1"});
    rd_stat({nm, "_stat2"});
    observe({nm, "_left"}, 32'(exp_pix_q.size()), 32'd0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int n;
    rst_n = 1'b0;
    sfr_addr = 8'h00;
    controller_data_in = 8'h00;
    sfr_wr = 1'b0;
    sfr_rd = 1'b0;
    m_idx = 0; m_busy = 0; m_done = 0; m_ovr = 0; m_repeat = 0; m_latch_ok = 0;

    // Reset state
    tick(3);
    observe("rst_valid", 32'(pix_valid), 32'd0);
    observe("rst_data", 32'(pix_data), 32'd0);
    observe("rst_done", 32'(frame_done), 32'd0);
    rst_n = 1'b1;
    tick(2);
    rd_stat("rst_stat");
    rd(A_IDX, 8'h00, "rst_idx");

    // 1: pixel k = {k, k+1, k+2}, always ready
    idx_wr(8'h00);
    for (int k = 0; k < N; k++) begin
      data_wr(8'(k)); data_wr(8'(k + 1)); data_wr(8'(k + 2));
    end
    rd(A_IDX, 8'(m_idx), "t1_idx");
    rdy_mode = 0;
    ctrl(8'h01);
    wait_done("t1");
    end_frame_checks("t1");

    // 2: 10-cycle stall on pixel 3
    rdy_mode  = 2;
    stall_val = m_buf[3];
    ctrl(8'h01);
    wait_done("t2");
    observe("t2_stall_len", 32'(stall_n), 32'd10);
    rdy_mode = 0;
    end_frame_checks("t2");

    // 3: wrap from IDX=7, partial lane survives, IDX modulo
    idx_wr(8'h07);
    for (int k = 0; k < 4; k++) data_wr(8'($urandom));
    rd(A_IDX, 8'(m_idx), "t3_idx_wrap");
    for (int k = 0; k < 2; k++) data_wr(8'($urandom));
    rd(A_IDX, 8'(m_idx), "t3_idx_lane");
    idx_wr(8'hFB);
    rd(A_IDX, 8'(m_idx), "t3_idx_mod");
    for (int k = 0; k < 3; k++) data_wr(8'($urandom));
    rd(A_IDX, 8'(m_idx), "t3_idx_after");
    rd(A_DATA, 8'h00, "t3_rd_data");
    rd(A_CTRL, 8'h00, "t3_rd_ctrl");
    rdy_mode = 1;
    ctrl(8'h01);
    wait_done("t3");
    rdy_mode = 0;
    end_frame_checks("t3");

    // 4: DATA write and START while SEND is stalled
    rdy_mode = 3;
    ctrl(8'h01);
    n = 0;
    while (!pix_valid && n < 100) begin tick(1); n++; end
    observe("t4_sending", 32'(pix_valid), 32'd1);
    data_wr(8'h55);
    ctrl(8'h01);
    rd_stat("t4_stat_busy");
    rd(A_IDX, 8'(m_idx), "t4_idx");
    rdy_mode = 0;
    wait_done("t4");
    tick(20);
    end_frame_checks("t4");

    // Random frames with random readiness
    for (int it = 0; it < 3; it++) begin
      idx_wr(8'($urandom));
      rd(A_IDX, 8'(m_idx), "rnd_idx0");
      n = $urandom_range(3, 30);
      for (int k = 0; k < n; k++) data_wr(8'($urandom));
      rd(A_IDX, 8'(m_idx), "rnd_idx1");
      rdy_mode = 1;
      ctrl(8'h01);
      wait_done("rnd");
      rdy_mode = 0;
      end_frame_checks("rnd");
    end

    // 5: reset during pixel 4
    rdy_mode = 0;
    ctrl(8'h01);
    n = 0;
    while (!(exp_pix_q.size() == N - 4 && pix_valid) && n < 200) begin tick(1); n++; end
    observe("t5_at_pix4", 32'(exp_pix_q.size()), 32'(N - 4));
    rst_n = 1'b0;
    #1;
    observe("t5_valid_async", 32'(pix_valid), 32'd0);
    exp_pix_q.delete();
    m_idx = 0; m_bytes.delete(); m_busy = 0; m_done = 0; m_ovr = 0; m_repeat = 0;
    tick(1);
    rst_n = 1'b1;
    tick(1);
    rd_stat("t5_stat");
    rd(A_IDX, 8'h00, "t5_idx");
    for (int k = 0; k < N; k++) begin
      data_wr(8'(8'h40 + k)); data_wr(8'(8'h41 + k)); data_wr(8'(8'h42 + k));
    end
    ctrl(8'h01);
    wait_done("t5");
    end_frame_checks("t5");

`ifdef AUTO_REPEAT_EN
    // 6: repeat frames, then stop from LATCH
    ctrl(8'h03);
    wait_done("t6_f1");
    rd_stat("t6_stat_f1");
    wait_done("t6_f2");
    rd_stat("t6_stat_f2");
    wait_drained("t6_drain");
    tick(3);
    m_latch_ok = 1'b1;
    idx_wr(8'h02);
    data_wr(8'h11);
    ctrl(8'h00);
    rd(A_IDX, 8'(m_idx), "t6_idx_latch");
    wait_done("t6_f3");
    tick(50);
    end_frame_checks("t6");
`else
    // 6: bit1 ignored, single frame; LATCH writes are overruns
    ctrl(8'h03);
    wait_drained("t6_drain");
    tick(3);
    data_wr(8'h77);
    wait_done("t6");
    tick(50);
    end_frame_checks("t6");
`endif

    tick(4);
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
